stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 10000000, CLK cycles per 100 ms count step; legal range >= 2.
REQ-002 Parameter MUX_DIV, default 50000, CLK cycles per DISP_TICK half-period; legal range >= 1.
REQ-003 CLK  input  1  system clock; one clock, rising-edge only.
REQ-004 RSTN  input  1  reset, asynchronous, active-low.
REQ-005 BTN_SS  input  1  start/stop request, already debounced, asynchronous to CLK; the rising edge is the event.
REQ-006 BTN_CLR  input  1  clear request, already debounced, asynchronous to CLK; the rising edge is the event.
REQ-007 DIGIT_1  output  4  BCD tenths-of-second digit, 0-9.
REQ-008 DIGIT_10  output  4  BCD seconds digit, 0-9.
REQ-009 TICK_100MS  output  1  one-cycle pulse per count step.
REQ-010 DISP_TICK  output  1  free-running square wave, drives the display mux toggle.
REQ-011 RUNNING  output  1  high while the FSM is in RUN.
REQ-012 OVF  output  1  sticky flag, set on wrap from 9.9 to 0.0.

Function
REQ-013 Each button input shall pass a 2-flop synchronizer plus one edge-detect flop.
- An input first sampled high at rising edge k shall produce its event at edge k+2.
- A held-high button shall produce exactly one event.
REQ-014 FSM states shall be IDLE, RUN and PAUSE; all state changes occur on the event edge.
REQ-015 IDLE: SS event -> RUN; CLR event -> stay in IDLE.
REQ-016 RUN: SS event -> PAUSE; CLR event ignored.
REQ-017 PAUSE: SS event -> RUN; CLR event -> IDLE.
REQ-018 Simultaneous SS and CLR events:
- In RUN, SS wins (go to PAUSE, no clear).
- In IDLE or PAUSE, CLR wins.
REQ-019 Any CLR event that is honoured, or that lands in IDLE, shall zero DIGIT_1, DIGIT_10, the prescaler and OVF on the same edge.
REQ-020 Prescaler PRE shall count 0..TICK_DIV-1 only in RUN, hold its value in PAUSE, and be forced to 0 in IDLE.
REQ-021 In RUN, at the edge where PRE==TICK_DIV-1:
- PRE <= 0.
- The digit pair increments by one step.
- TICK_100MS is high for exactly the following cycle.
REQ-022 Increment rule:
- DIGIT_1 counts 0..9.
- When DIGIT_1 wraps 9->0, DIGIT_10 increments.
- At 9.9 the next step gives 0.0, sets OVF, and counting continues.
REQ-023 The edge that carries RUN->PAUSE shall not also increment the digits, even if PRE==TICK_DIV-1.
- PRE is held at TICK_DIV-1.
- The step fires on the first RUN edge after resume.
REQ-024 DISP_TICK shall be generated by its own counter, independent of the FSM state.
- The counter runs 0..MUX_DIV-1.
- DISP_TICK toggles at each counter wrap.
REQ-025 DIGIT_1, DIGIT_10 and RUNNING shall be registered outputs, valid from the edge on which they change, and never out of BCD range.
REQ-026 OVF shall stay set until an honoured CLR event or reset.

Reset
REQ-027 While RSTN is low, asynchronously and immediately:
- DIGIT_1=0, DIGIT_10=0, TICK_100MS=0, DISP_TICK=0, RUNNING=0, OVF=0.
- FSM=IDLE, PRE=0, mux counter=0, synchronizer and edge flops=0.
REQ-028 A button held high across reset deassertion shall be seen as level, not as an edge.
- It shall produce no event until it goes low and then high again.
REQ-029 Reset asserted mid-count shall abandon the count; there is no count retention.

Verification (TICK_DIV=4, MUX_DIV=2)
REQ-030 Reset release, no buttons for 20 cycles -> all outputs 0, DISP_TICK toggles every 2 cycles, DIGIT pair stays 0.0.
REQ-031 SS pulse -> RUNNING=1 two edges after sampling; TICK_100MS every 4 cycles; digits step 0.0, 0.1 ... 0.9, 1.0.
REQ-032 Run 100 steps -> 9.9 then 0.0 with OVF=1; OVF still 1 after 5 more steps.
REQ-033 Pause at 3.7, then CLR, then SS and CLR on the same cycle in PAUSE -> digits 0.0, OVF=0, state IDLE, RUNNING=0.
REQ-034 In RUN, CLR alone -> no change; SS and CLR on the same cycle -> PAUSE with digits held.
REQ-035 RSTN low mid-run at 5.2 -> outputs 0 asynchronously; BTN_SS held high through release -> no start until it is re-pressed.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Two-digit (s.d) stopwatch controller: button synchronisers, IDLE/RUN/PAUSE FSM,
// 100 ms prescaler, BCD digit counter with sticky overflow, free-running display-mux tick.
module stopwatch_ctrl #(
    parameter int TICK_DIV = 10000000,
    parameter int MUX_DIV  = 50000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       btn_ss,
    input  logic       btn_clr,
    output logic [3:0] digit_1,
    output logic [3:0] digit_10,
    output logic       tick_100ms,
    output logic       disp_tick,
    output logic       running,
    output logic       ovf
);

    localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int MUX_W = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [MUX_W-1:0] MUX_LAST = MUX_W'(MUX_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Button synchronisers and rising-edge detectors (bit 0 = SS, bit 1 = CLR)
    // ------------------------------------------------------------------
    logic [1:0] btn_raw;
    logic [1:0] btn_event;
    logic [1:0] valid_reg;

    assign btn_raw = {btn_clr, btn_ss};

    // valid_reg[1] marks that the second synchroniser stage holds a real sample
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_reg <= 2'b00;
        end else begin
            valid_reg <= {valid_reg[0], 1'b1};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic sync1_reg;
            logic sync2_reg;
            logic edge_reg;
            logic armed_reg;

            // Edges are only honoured once the button has been seen low after
            // reset, so a button held through reset release is treated as a level.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    edge_reg  <= 1'b0;
                    armed_reg <= 1'b0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    edge_reg  <= sync2_reg;
                    if (valid_reg[1] && !sync2_reg) begin
                        armed_reg <= 1'b1;
                    end
                end
            end

            assign btn_event[gi] = sync2_reg & ~edge_reg & armed_reg;
        end
    endgenerate

    logic ss_event;
    logic clr_event;

    assign ss_event  = btn_event[0];
    assign clr_event = btn_event[1];

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    state_t state_reg;
    state_t state_next;
    logic   clear_en;
    logic   count_en;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        clear_en   = 1'b0;
        count_en   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (clr_event) begin
                    clear_en = 1'b1;
                end else if (ss_event) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                // The stopping edge neither advances the prescaler nor steps the digits
                if (ss_event) begin
                    state_next = PAUSE;
                end else begin
                    count_en = 1'b1;
                end
            end
            PAUSE: begin
                if (clr_event) begin
                    state_next = IDLE;
                    clear_en   = 1'b1;
                end else if (ss_event) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = IDLE;
                clear_en   = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Prescaler and BCD digit counter
    // ------------------------------------------------------------------
    logic [PRE_W-1:0] pre_reg;
    logic [PRE_W-1:0] pre_next;
    logic [3:0]       d1_reg;
    logic [3:0]       d1_next;
    logic [3:0]       d10_reg;
    logic [3:0]       d10_next;
    logic             ovf_reg;
    logic             ovf_next;
    logic             tick_reg;
    logic             tick_next;
    logic             running_reg;

    always_comb begin
        pre_next  = pre_reg;
        d1_next   = d1_reg;
        d10_next  = d10_reg;
        ovf_next  = ovf_reg;
        tick_next = 1'b0;
        if (clear_en) begin
            pre_next = '0;
            d1_next  = 4'd0;
            d10_next = 4'd0;
            ovf_next = 1'b0;
        end else if (count_en) begin
            if (pre_reg == PRE_LAST) begin
                pre_next  = '0;
                tick_next = 1'b1;
                if (d1_reg >= 4'd9) begin
                    d1_next = 4'd0;
                    if (d10_reg >= 4'd9) begin
                        d10_next = 4'd0;
                        ovf_next = 1'b1;
                    end else begin
                        d10_next = d10_reg + 4'd1;
                    end
                end else begin
                    d1_next = d1_reg + 4'd1;
                end
            end else begin
                pre_next = pre_reg + PRE_W'(1);
            end
        end else if (state_reg == IDLE) begin
            pre_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pre_reg     <= '0;
            d1_reg      <= 4'd0;
            d10_reg     <= 4'd0;
            ovf_reg     <= 1'b0;
            tick_reg    <= 1'b0;
            running_reg <= 1'b0;
        end else begin
            pre_reg     <= pre_next;
            d1_reg      <= d1_next;
            d10_reg     <= d10_next;
            ovf_reg     <= ovf_next;
            tick_reg    <= tick_next;
            running_reg <= (state_next == RUN);
        end
    end

    // ------------------------------------------------------------------
    // Display multiplex tick, independent of the FSM
    // ------------------------------------------------------------------
    logic [MUX_W-1:0] mux_cnt_reg;
    logic             disp_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mux_cnt_reg <= '0;
            disp_reg    <= 1'b0;
        end else if (mux_cnt_reg == MUX_LAST) begin
            mux_cnt_reg <= '0;
            disp_reg    <= ~disp_reg;
        end else begin
            mux_cnt_reg <= mux_cnt_reg + MUX_W'(1);
        end
    end

    assign digit_1    = d1_reg;
    assign digit_10   = d10_reg;
    assign ovf        = ovf_reg;
    assign tick_100ms = tick_reg;
    assign running    = running_reg;
    assign disp_tick  = disp_reg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with TICK_DIV=4, MUX_DIV=2: a table of button
// operations with hand-derived expectations, plus hand-written reset/synchroniser sequences.
module tb_stopwatch_ctrl;

    logic       clk;
    logic       rstn;
    logic       btn_ss;
    logic       btn_clr;
    logic [3:0] digit_1;
    logic [3:0] digit_10;
    logic       tick_100ms;
    logic       disp_tick;
    logic       running;
    logic       ovf;

    stopwatch_ctrl #(
        .TICK_DIV(4),
        .MUX_DIV (2)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .btn_ss    (btn_ss),
        .btn_clr   (btn_clr),
        .digit_1   (digit_1),
        .digit_10  (digit_10),
        .tick_100ms(tick_100ms),
        .disp_tick (disp_tick),
        .running   (running),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int tick_cnt = 0;

    // Count count-step pulses shortly after each active edge
    always @(posedge clk) begin
        #1;
        if (tick_100ms === 1'b1) tick_cnt++;
    end

    typedef struct {
        string name;
        bit    ss;
        bit    clr;
        int    wait_cyc;
        int    d10;
        int    d1;
        int    run;
        int    ovf;
        int    ticks;
    } vec_t;

    typedef struct {
        string name;
        int    d10;
        int    d1;
        int    run;
        int    ovf;
        int    ticks;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input bit ss, input bit clr, input int w,
                                input int d10, input int d1, input int run, input int ov,
                                input int ticks);
        vec_t v;
        v.name = name; v.ss = ss; v.clr = clr; v.wait_cyc = w;
        v.d10 = d10; v.d1 = d1; v.run = run; v.ovf = ov; v.ticks = ticks;
        return v;
    endfunction

    // Entered at a falling edge: press for three active edges (event on the third), release,
    // wait wait_cyc edges, then compare at the next falling edge.
    task automatic apply(input vec_t v);
        exp_t e;
        int   t0;
        e.name = v.name; e.d10 = v.d10; e.d1 = v.d1;
        e.run = v.run; e.ovf = v.ovf; e.ticks = v.ticks;
        sb.push_back(e);
        t0 = tick_cnt;
        if (v.ss || v.clr) begin
            btn_ss  = v.ss;
            btn_clr = v.clr;
            repeat (3) @(posedge clk);
            @(negedge clk);
            btn_ss  = 1'b0;
            btn_clr = 1'b0;
        end
        repeat (v.wait_cyc) @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        check({e.name, "/digit_10"}, digit_10, e.d10);
        check({e.name, "/digit_1"}, digit_1, e.d1);
        check({e.name, "/running"}, running, e.run);
        check({e.name, "/ovf"}, ovf, e.ovf);
        check({e.name, "/ticks"}, tick_cnt - t0, e.ticks);
        $display("vec %-14s ss=%0b clr=%0b -> %0d.%0d run=%0b ovf=%0b ticks=%0d",
                 e.name, v.ss, v.clr, digit_10, digit_1, running, ovf, tick_cnt - t0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn    = 1'b0;
        btn_ss  = 1'b0;
        btn_clr = 1'b0;

        // Expected digit pair = (counted RUN edges / 4) mod 100
        vecs.push_back(mk("idle",         0, 0,   4, 0, 0, 0, 0,  0));
        vecs.push_back(mk("start",        1, 0,  40, 1, 0, 1, 0, 10));
        vecs.push_back(mk("to_9.9",       0, 0, 356, 9, 9, 1, 0, 89));
        vecs.push_back(mk("wrap",         0, 0,   4, 0, 0, 1, 1,  1));
        vecs.push_back(mk("ovf_sticky",   0, 0,  20, 0, 5, 1, 1,  5));
        vecs.push_back(mk("clr_in_run",   0, 1,   1, 0, 6, 1, 1,  1));
        vecs.push_back(mk("ss_clr_run",   1, 1,   4, 0, 6, 0, 1,  0));
        vecs.push_back(mk("resume",       1, 0, 122, 3, 7, 1, 1, 31));
        vecs.push_back(mk("pause_3.7",    1, 0,   4, 3, 7, 0, 1,  0));
        vecs.push_back(mk("ss_clr_pause", 1, 1,   4, 0, 0, 0, 0,  0));
        vecs.push_back(mk("restart",      1, 0,   9, 0, 2, 1, 0,  2));
        vecs.push_back(mk("pause_pre3",   1, 0,   4, 0, 2, 0, 0,  0));
        vecs.push_back(mk("resume_step",  1, 0,   1, 0, 3, 1, 0,  1));
        vecs.push_back(mk("pause_again",  1, 0,   4, 0, 3, 0, 0,  0));
        vecs.push_back(mk("clr_pause",    0, 1,   4, 0, 0, 0, 0,  0));
        vecs.push_back(mk("ss_clr_idle",  1, 1,   8, 0, 0, 0, 0,  0));
        vecs.push_back(mk("clr_idle",     0, 1,   4, 0, 0, 0, 0,  0));

        // Reset state
        repeat (3) @(negedge clk);
        check("rst/digit_1", digit_1, 0);
        check("rst/digit_10", digit_10, 0);
        check("rst/tick", tick_100ms, 0);
        check("rst/disp_tick", disp_tick, 0);
        check("rst/running", running, 0);
        check("rst/ovf", ovf, 0);
        $display("reset: %0d.%0d run=%0b ovf=%0b disp=%0b", digit_10, digit_1, running, ovf, disp_tick);

        // Idle after release: display tick toggles every second edge
        rstn = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            check("disp_tick", disp_tick, (n / 2) % 2);
        end
        check("idle20/digit_1", digit_1, 0);
        check("idle20/digit_10", digit_10, 0);
        check("idle20/running", running, 0);
        check("idle20/ovf", ovf, 0);
        $display("idle 20 cycles: %0d.%0d run=%0b disp=%0b", digit_10, digit_1, running, disp_tick);

        foreach (vecs[i]) apply(vecs[i]);

        // Synchroniser latency and single event for a held button
        btn_ss = 1'b1;
        @(posedge clk); @(negedge clk);
        check("sync/edge_k", running, 0);
        @(posedge clk); @(negedge clk);
        check("sync/edge_k1", running, 0);
        @(posedge clk); @(negedge clk);
        check("sync/edge_k2", running, 1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("held/running", running, 1);
        check("held/digit_1", digit_1, 5);
        $display("held start: %0d.%0d run=%0b", digit_10, digit_1, running);

        // Reset mid-count abandons the count
        btn_ss = 1'b0;
        rstn   = 1'b0;
        #1;
        check("async1/digit_1", digit_1, 0);
        check("async1/running", running, 0);
        check("async1/disp_tick", disp_tick, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        btn_ss = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        btn_ss = 1'b0;
        repeat (208) @(posedge clk);
        @(negedge clk);
        check("run_5.2/digit_10", digit_10, 5);
        check("run_5.2/digit_1", digit_1, 2);
        $display("run to 5.2: %0d.%0d run=%0b", digit_10, digit_1, running);

        btn_ss = 1'b1;
        #2;
        rstn = 1'b0;
        #1;
        check("async2/digit_10", digit_10, 0);
        check("async2/digit_1", digit_1, 0);
        check("async2/running", running, 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        check("held_rst/running", running, 0);
        check("held_rst/digit_1", digit_1, 0);
        $display("ss held through reset: %0d.%0d run=%0b", digit_10, digit_1, running);

        btn_ss = 1'b0;
        repeat (4) @(negedge clk);
        btn_ss = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("repress/running", running, 1);
        btn_ss = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("repress/digit_1", digit_1, 1);
        $display("re-press: %0d.%0d run=%0b", digit_10, digit_1, running);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
